// File: rtl/fifo_arb_pkg.sv
// Shared types and the round-robin search used by the fifo_dram write arbiter.
// Requester indices are carried in IDX_MAX_W bits so one function serves every NUM_REQ up to MAX_REQ.
package fifo_arb_pkg;

  localparam int MAX_REQ   = 8;
  localparam int IDX_MAX_W = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_e;

  // First set bit of valid, searching upward from last+1 and wrapping at num_req.
  function automatic logic [IDX_MAX_W-1:0] next_rr_index(
    input logic [MAX_REQ-1:0]   valid,
    input logic [IDX_MAX_W-1:0] last,
    input int                   num_req
  );
    logic [IDX_MAX_W-1:0] idx;
    logic [IDX_MAX_W-1:0] cand;
    logic                 found;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      cand = IDX_MAX_W'((int'(last) + k) % num_req);
      if (!found && (k <= num_req) && valid[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: one-hot and index of the next valid requester after last.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   last,
  output logic               any,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IDX_W-1:0]   idx
);

  logic [MAX_REQ-1:0]   valid_ext;
  logic [IDX_MAX_W-1:0] pick;

  assign valid_ext = MAX_REQ'(valid);
  assign pick      = next_rr_index(valid_ext, IDX_MAX_W'(last), NUM_REQ);
  assign idx       = IDX_W'(pick);
  assign any       = |valid;

  always_comb begin
    onehot = '0;
    if (any) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the fifo_dram write port among NUM_REQ byte sources,
// granting one source at a time for at most MAX_BURST bytes and stalling on fifo_full.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 4,
  parameter int DATA_W    = 8,
  parameter int CNT_W     = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      arb_en,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      fifo_full,
  output logic                      fifo_wr_en,
  output logic [DATA_W-1:0]         fifo_datain,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      busy,
  output logic [CNT_W-1:0]          wr_count
);

  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BCNT_W = 4;

  arb_state_e          state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [IDX_W-1:0]    gidx_q, gidx_d;
  logic [IDX_W-1:0]    last_q, last_d;
  logic [BCNT_W-1:0]   burst_cnt_q, burst_cnt_d;
  logic [CNT_W-1:0]    wr_count_q, wr_count_d;

  logic                pick_any;
  logic [NUM_REQ-1:0]  pick_onehot;
  logic [IDX_W-1:0]    pick_idx;
  logic                in_burst, g_valid, accept;
  logic [DATA_W-1:0]   g_data;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .valid  (req_valid),
    .last   (last_q),
    .any    (pick_any),
    .onehot (pick_onehot),
    .idx    (pick_idx)
  );

  // NOTE: every signal driven in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    g_valid = 1'b0;
    g_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gidx_q == IDX_W'(i)) begin
        g_valid = req_valid[i];
        g_data  = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign in_burst    = (state_q == ST_BURST);
  assign accept      = in_burst & g_valid & ~fifo_full;
  assign req_ready   = (in_burst && !fifo_full) ? grant_q : '0;
  assign fifo_wr_en  = accept;
  assign fifo_datain = accept ? g_data : '0;
  assign grant       = grant_q;
  assign busy        = in_burst;
  assign wr_count    = wr_count_q;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    gidx_d      = gidx_q;
    last_d      = last_q;
    burst_cnt_d = burst_cnt_q;
    wr_count_d  = wr_count_q + CNT_W'(accept);
    unique case (state_q)
      ST_IDLE: begin
        if (arb_en && pick_any) begin
          state_d     = ST_BURST;
          grant_d     = pick_onehot;
          gidx_d      = pick_idx;
          burst_cnt_d = '0;
        end
      end
      ST_BURST: begin
        if (accept) burst_cnt_d = burst_cnt_q + 1'b1;
        // A full stall leaves both the count and the grant untouched.
        if (!g_valid || (accept && (burst_cnt_q == BCNT_W'(MAX_BURST - 1)))) begin
          state_d = ST_IDLE;
          grant_d = '0;
          last_d  = gidx_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      gidx_q      <= '0;
      last_q      <= IDX_W'(NUM_REQ - 1);
      burst_cnt_q <= '0;
      wr_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      gidx_q      <= gidx_d;
      last_q      <= last_d;
      burst_cnt_q <= burst_cnt_d;
      wr_count_q  <= wr_count_d;
    end
  end

endmodule
